multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle RV32I core. Sequences the shared ALU, instruction register, PC, register file and unified memory port across FETCH/DECODE/EXECUTE/MEM/WB steps, and decodes ALU operation codes. Consumes the registered instruction (same word the immediate extender consumes) plus ALU compare flags. Drives datapath mux selects and write strobes.

---
 rtl/multicycle_ctrl_if.sv | 36 +++
 rtl/multicycle_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the multicycle RV32I controller: decoded instruction
// and ALU flags in, mux selects, write strobes and the memory handshake out.
interface multicycle_ctrl_if #(
    parameter int ALUCTL_W = 4
);
    logic [31:0]         instr;
    logic                zero;
    logic                lt;
    logic                ltu;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_write;
    logic                adr_src;
    logic                ir_write;
    logic                pc_write;
    logic                pc_clr_lsb;
    logic                reg_write;
    logic [1:0]          alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          result_src;
    logic [ALUCTL_W-1:0] alu_ctl;
    logic                instr_retired;
    logic                illegal_instr;

    modport master (
        input  instr, zero, lt, ltu, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, pc_clr_lsb, reg_write,
               alu_src_a, alu_src_b, result_src, alu_ctl, instr_retired, illegal_instr
    );

    modport slave (
        output instr, zero, lt, ltu, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, pc_clr_lsb, reg_write,
               alu_src_a, alu_src_b, result_src, alu_ctl, instr_retired, illegal_instr
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core (FETCH/DECODE/EXECUTE/MEM/WB).
// Optional ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP until reset.
module multicycle_ctrl #(
    parameter int ALUCTL_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK,
        S_LUI, S_AUIPC
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    state_t state, next;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       bit30;
    logic       taken;
    logic       unused;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, pc_clr_lsb, reg_write;
    logic       instr_retired;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_op;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign bit30  = bus.instr[30];
    assign unused = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    // instr[30] means SUB only for register ops; for both forms it picks SRA on shifts.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic b30,
                                              input logic is_reg);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_reg && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        case (funct3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = ~bus.zero;
            3'b100:  taken = bus.lt;
            3'b101:  taken = ~bus.lt;
            3'b110:  taken = bus.ltu;
            3'b111:  taken = ~bus.ltu;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next;
    end

    always_comb begin
        next          = state;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_clr_lsb    = 1'b0;
        reg_write     = 1'b0;
        instr_retired = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        alu_op        = ALU_ADD;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_write   = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    pc_write   = 1'b1;
                    next       = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/JAL target is precomputed here into ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    7'b0000011, 7'b0100011: next = S_MEMADR;
                    7'b0110011:             next = S_EXECR;
                    7'b0010011:             next = S_EXECI;
                    7'b1100011:             next = S_BRANCH;
                    7'b1101111:             next = S_JAL;
                    7'b1100111:             next = S_JALR;
                    7'b0110111:             next = S_LUI;
                    7'b0010111:             next = S_AUIPC;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        next = S_TRAP;
`else
                        instr_retired = 1'b1;
                        next          = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                next      = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                mem_req = 1'b1;
                if (bus.mem_ready) next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                next          = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_req   = 1'b1;
                mem_write = 1'b1;
                if (bus.mem_ready) begin
                    instr_retired = 1'b1;
                    next          = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = alu_decode(funct3, bit30, 1'b1);
                next      = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = alu_decode(funct3, bit30, 1'b0);
                next      = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                next          = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 2'b10;
                alu_op        = ALU_SUB;
                pc_write      = taken;
                instr_retired = 1'b1;
                next          = S_FETCH;
            end
            S_JAL: begin
                pc_write  = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                next      = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
                pc_clr_lsb = 1'b1;
                next       = S_LINK;
            end
            S_LINK: begin
                alu_src_a     = 2'b01;
                alu_src_b     = 2'b10;
                result_src    = 2'b10;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                next          = S_FETCH;
            end
            S_LUI: begin
                alu_src_b = 2'b01;
                alu_op    = ALU_PASSB;
                next      = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                next      = S_ALUWB;
            end
            default: next = state;
        endcase
        // Reset forces FETCH asynchronously; keep it from issuing a fetch while held.
        if (reset) begin
            mem_req       = 1'b0;
            mem_write     = 1'b0;
            adr_src       = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_clr_lsb    = 1'b0;
            reg_write     = 1'b0;
            instr_retired = 1'b0;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b00;
            result_src    = 2'b00;
            alu_op        = ALU_ADD;
        end
    end

    assign bus.mem_req       = mem_req;
    assign bus.mem_write     = mem_write;
    assign bus.adr_src       = adr_src;
    assign bus.ir_write      = ir_write;
    assign bus.pc_write      = pc_write;
    assign bus.pc_clr_lsb    = pc_clr_lsb;
    assign bus.reg_write     = reg_write;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.result_src    = result_src;
    assign bus.alu_ctl       = ALUCTL_W'(alu_op);
    assign bus.instr_retired = instr_retired;
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal_instr = (state == S_TRAP) && !reset;
`else
    assign bus.illegal_instr = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed reset/memory-wait cases plus
// random instruction streams judged by an instruction-level model.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   ncmp = 0;
    int   nerr = 0;

    multicycle_ctrl_if #(.ALUCTL_W(4)) bus ();
    multicycle_ctrl #(.ALUCTL_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {13'd0, bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
                bus.pc_clr_lsb, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.result_src,
                bus.alu_ctl, bus.instr_retired, bus.illegal_instr};
    endfunction

    // ISA meaning of the ALU operation for OP / OP-IMM instructions.
    function automatic logic [3:0] isa_op(input logic [2:0] f3, input logic b30, input bit is_reg);
        logic [3:0] tbl [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        if (f3 == 3'd0 && is_reg && b30) return 4'd1;
        if (f3 == 3'd5 && b30)           return 4'd9;
        return tbl[f3];
    endfunction

    function automatic bit is_legal(input logic [6:0] opc);
        return opc inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    endfunction

    // Run one instruction from FETCH to retirement, with fw/dw memory wait cycles.
    task automatic run_instr(input string tag, input logic [31:0] ins, input int fw, input int dw,
                             input logic z, input logic l, input logic lu);
        logic [6:0] opc = ins[6:0];
        logic [2:0] f3  = ins[14:12];
        bit   mem = 0, st = 0, taken = 0;
        int   lat = 4, rw_exp = 1, pcw_exp = 1, rs_exp = 0, clr_exp = 0;
        logic [3:0] alu_exp = 4'd0;
        int   cyc = 0, mreq = 0, mw = 0, rw = 0, pcw = 0, clr = 0, rs = 3, ill = 0;
        bit   done = 0, seen = 0;

        case (opc)
            7'h03: begin mem = 1; lat = 5; rs_exp = 1; end
            7'h23: begin mem = 1; st = 1; rw_exp = 0; end
            7'h33: alu_exp = isa_op(f3, ins[30], 1);
            7'h13: alu_exp = isa_op(f3, ins[30], 0);
            7'h63: begin
                case (f3)
                    3'd0: taken = z;   3'd1: taken = !z;
                    3'd4: taken = l;   3'd5: taken = !l;
                    3'd6: taken = lu;  3'd7: taken = !lu;
                    default: taken = 0;
                endcase
                lat = 3; rw_exp = 0; alu_exp = 4'd1; pcw_exp = 1 + int'(taken);
            end
            7'h6F: pcw_exp = 2;
            7'h67: begin pcw_exp = 2; rs_exp = 2; clr_exp = 1; end
            7'h37: alu_exp = 4'd10;
            7'h17: ;
            default: begin lat = 2; rw_exp = 0; end
        endcase
        if (rw_exp == 0) rs_exp = 3;

        bus.instr = ins; bus.zero = z; bus.lt = l; bus.ltu = lu;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (bus.mem_req) begin
                if (mreq < fw)                bus.mem_ready = 1'b0;
                else if (mreq == fw)          bus.mem_ready = 1'b1;
                else if (mreq - fw - 1 < dw)  bus.mem_ready = 1'b0;
                else                          bus.mem_ready = 1'b1;
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (bus.mem_req) begin mreq++; if (bus.mem_write) mw++; end
            if (bus.reg_write) begin rw++; rs = int'(bus.result_src); end
            if (bus.pc_write) pcw++;
            if (bus.pc_clr_lsb) clr++;
            if (bus.alu_ctl == alu_exp) seen = 1;
            if (bus.illegal_instr) ill++;
            cyc++;
            if (bus.instr_retired) done = 1;
        end
        check({tag, ".retired"}, 32'(done), 32'd1);
        check({tag, ".cycles"}, cyc, lat + fw + (mem ? dw : 0));
        check({tag, ".mem_req_cycles"}, mreq, fw + 1 + (mem ? dw + 1 : 0));
        check({tag, ".mem_write_cycles"}, mw, st ? dw + 1 : 0);
        check({tag, ".reg_write"}, rw, rw_exp);
        check({tag, ".result_src"}, rs, rs_exp);
        check({tag, ".pc_write"}, pcw, pcw_exp);
        check({tag, ".pc_clr_lsb"}, clr, clr_exp);
        check({tag, ".alu_ctl_seen"}, 32'(seen), 32'd1);
        check({tag, ".illegal"}, ill, 0);
    endtask

    initial begin
        logic [31:0] ins;
        logic [6:0]  opc;
        logic [6:0]  legal [9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        int          ncls;

        // Reset asserted mid-FETCH with memory not ready.
        reset = 1'b1; bus.mem_ready = 1'b0; bus.instr = 32'h0;
        bus.zero = 1'b0; bus.lt = 1'b0; bus.ltu = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.outputs", all_outs(), 32'd0);
        reset = 1'b0;
        #1;
        check("post_reset.mem_req", 32'(bus.mem_req), 32'd1);
        check("post_reset.pc_write", 32'(bus.pc_write), 32'd0);
        repeat (2) @(negedge clk);
        check("fetch_hold.mem_req", 32'(bus.mem_req), 32'd1);
        check("fetch_hold.strobes", {bus.pc_write, bus.ir_write, bus.instr_retired}, 32'd0);

        // Directed instructions.
        run_instr("add",  32'h002081B3, 0, 0, 0, 0, 0);
        run_instr("sub",  32'h402081B3, 0, 0, 0, 0, 0);
        run_instr("srai", 32'h4020D193, 0, 0, 0, 0, 0);
        run_instr("lw_wait", 32'h0000A183, 0, 2, 0, 0, 0);
        run_instr("sw_wait", 32'h0020A023, 1, 3, 0, 0, 0);
        run_instr("beq_t", 32'h00208463, 0, 0, 1, 0, 0);
        run_instr("beq_nt", 32'h00208463, 0, 0, 0, 0, 0);
        run_instr("bltu_nt", 32'h0020E463, 0, 0, 0, 1, 0);
        run_instr("jalr", 32'h000080E7, 0, 0, 0, 0, 0);
`ifndef ILLEGAL_TRAP_EN
        run_instr("nop_7f", 32'h0000007F, 0, 0, 0, 0, 0);
`endif

        // Reset during a data-memory wait drops the request at once.
        bus.instr = 32'h0000A183;
        @(negedge clk); bus.mem_ready = 1'b1;
        @(negedge clk); bus.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("memread.req", {bus.mem_req, bus.adr_src}, 32'd3);
        reset = 1'b1;
        #1;
        check("memread_reset.mem_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk); reset = 1'b0;
        #1;
        check("after_abort.fetch", {bus.mem_req, bus.adr_src}, 32'd2);

`ifdef ILLEGAL_TRAP_EN
        bus.instr = 32'h0000007F;
        @(negedge clk); bus.mem_ready = 1'b1;
        @(negedge clk); bus.mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check("trap.illegal", 32'(bus.illegal_instr), 32'd1);
            check("trap.quiet", {bus.mem_req, bus.pc_write, bus.reg_write, bus.instr_retired}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("trap_reset.illegal", 32'(bus.illegal_instr), 32'd0);
        reset = 1'b0;
`endif

        // Random instruction stream.
`ifdef ILLEGAL_TRAP_EN
        ncls = 9;
`else
        ncls = 10;
`endif
        for (int n = 0; n < 200; n++) begin
            int c = $urandom_range(0, ncls - 1);
            ins = $urandom;
            if (c < 9) begin
                opc = legal[c];
            end else begin
                opc = 7'($urandom);
                while (is_legal(opc)) opc = 7'($urandom);
            end
            ins[6:0] = opc;
            run_instr($sformatf("rnd%0d_%08h", n, ins), ins, $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
